// File: rtl/sprite_scheduler.sv
// Per-pixel sprite scheduler: shadow/active slot banks, fixed-priority hit test, shared ROM
// address generation and a two-stage pixel pipeline.
module sprite_scheduler #(
   parameter int unsigned NUM_SPRITES = 4,
   parameter int unsigned SPR_W       = 25,
   parameter int unsigned SPR_H       = 25,
   parameter int unsigned ID_W        = 3,
   parameter int unsigned ADDR_W      = 13,
   parameter int unsigned COMMIT_Y    = 480,
   localparam int unsigned SLOT_W     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
   input  logic              vga_clk,
   input  logic              Reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic              cfg_we,
   input  logic [SLOT_W-1:0] cfg_slot,
   input  logic [9:0]        cfg_x,
   input  logic [9:0]        cfg_y,
   input  logic [ID_W-1:0]   cfg_id,
   input  logic              cfg_en,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [3:0]        rom_q,
   output logic [3:0]        pix_index,
   output logic              pix_hit,
   output logic [SLOT_W-1:0] pix_slot,
   output logic              frame_commit
);

   logic [9:0]             sh_x  [NUM_SPRITES];
   logic [9:0]             sh_y  [NUM_SPRITES];
   logic [ID_W-1:0]        sh_id [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] sh_en;
   logic [9:0]             act_x  [NUM_SPRITES];
   logic [9:0]             act_y  [NUM_SPRITES];
   logic [ID_W-1:0]        act_id [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] act_en;

   logic commit;
   assign commit = (DrawX == 10'd0) && (DrawY == 10'(COMMIT_Y));

   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            sh_x[i]  <= '0;
            sh_y[i]  <= '0;
            sh_id[i] <= '0;
         end
         sh_en <= '0;
      end else if (cfg_we && (32'(cfg_slot) < NUM_SPRITES)) begin
         sh_x[cfg_slot]  <= cfg_x;
         sh_y[cfg_slot]  <= cfg_y;
         sh_id[cfg_slot] <= cfg_id;
         sh_en[cfg_slot] <= cfg_en;
      end
   end

   // Copy reads shadow as it stood before this edge, so a same-cycle write waits a frame.
   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            act_x[i]  <= '0;
            act_y[i]  <= '0;
            act_id[i] <= '0;
         end
         act_en <= '0;
      end else if (commit) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            act_x[i]  <= sh_x[i];
            act_y[i]  <= sh_y[i];
            act_id[i] <= sh_id[i];
         end
         act_en <= sh_en;
      end
   end

   logic [NUM_SPRITES-1:0] hit_vec;
   logic                   win;
   logic [SLOT_W-1:0]      win_slot;
   logic [10:0]            win_dx;
   logic [10:0]            win_dy;
   logic [ID_W-1:0]        win_id;
   logic [ADDR_W-1:0]      addr_d;

   // 11-bit compares keep x+SPR_W from wrapping past 1023.
   always_comb begin
      hit_vec  = '0;
      win      = 1'b0;
      win_slot = '0;
      win_dx   = '0;
      win_dy   = '0;
      win_id   = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         hit_vec[i] = act_en[i] && blank &&
                      ({1'b0, DrawX} >= {1'b0, act_x[i]}) &&
                      ({1'b0, DrawX} <  ({1'b0, act_x[i]} + 11'(SPR_W))) &&
                      ({1'b0, DrawY} >= {1'b0, act_y[i]}) &&
                      ({1'b0, DrawY} <  ({1'b0, act_y[i]} + 11'(SPR_H)));
      end
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            win      = 1'b1;
            win_slot = SLOT_W'(i);
            win_dx   = {1'b0, DrawX} - {1'b0, act_x[i]};
            win_dy   = {1'b0, DrawY} - {1'b0, act_y[i]};
            win_id   = act_id[i];
         end
      end
      addr_d = '0;
      if (win) begin
         addr_d = ADDR_W'(win_id) * ADDR_W'(SPR_W * SPR_H) +
                  ADDR_W'(win_dy) * ADDR_W'(SPR_W) + ADDR_W'(win_dx);
      end
   end

   logic              hit1;
   logic [SLOT_W-1:0] slot1;

   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         rom_address  <= '0;
         hit1         <= 1'b0;
         slot1        <= '0;
         pix_index    <= '0;
         pix_hit      <= 1'b0;
         pix_slot     <= '0;
         frame_commit <= 1'b0;
      end else begin
         rom_address  <= addr_d;
         hit1         <= win;
         slot1        <= win_slot;
         pix_index    <= hit1 ? rom_q : 4'd0;
         pix_hit      <= hit1 && (rom_q != 4'd0);
         pix_slot     <= hit1 ? slot1 : '0;
         frame_commit <= commit;
      end
   end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed, table-driven bench for sprite_scheduler with a negedge-read ROM model.
module tb_sprite_scheduler;

   logic        vga_clk = 1'b0;
   logic        Reset;
   logic [9:0]  DrawX, DrawY;
   logic        blank;
   logic        cfg_we;
   logic [1:0]  cfg_slot;
   logic [9:0]  cfg_x, cfg_y;
   logic [2:0]  cfg_id;
   logic        cfg_en;
   logic [12:0] rom_address;
   logic [3:0]  rom_q;
   logic [3:0]  pix_index;
   logic        pix_hit;
   logic [1:0]  pix_slot;
   logic        frame_commit;

   int n_checks = 0;
   int n_fail   = 0;
   int rom_val  = 0;

   sprite_scheduler dut (
      .vga_clk      (vga_clk),
      .Reset        (Reset),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .blank        (blank),
      .cfg_we       (cfg_we),
      .cfg_slot     (cfg_slot),
      .cfg_x        (cfg_x),
      .cfg_y        (cfg_y),
      .cfg_id       (cfg_id),
      .cfg_en       (cfg_en),
      .rom_address  (rom_address),
      .rom_q        (rom_q),
      .pix_index    (pix_index),
      .pix_hit      (pix_hit),
      .pix_slot     (pix_slot),
      .frame_commit (frame_commit)
   );

   always #5 vga_clk = ~vga_clk;

   // ROM answers on the falling edge; the bench chooses the colour index per vector.
   always @(negedge vga_clk) rom_q <= 4'(rom_val);

   typedef struct {
      int grp;
      int x;
      int y;
      bit b;
      int romv;
      int addr;
      int idx;
      bit hit;
      int slot;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   task automatic step();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cfg_write(input int s, input int x, input int y, input int id, input int en);
      cfg_slot = 2'(s);
      cfg_x    = 10'(x);
      cfg_y    = 10'(y);
      cfg_id   = 3'(id);
      cfg_en   = 1'(en);
      cfg_we   = 1'b1;
      step();
      cfg_we   = 1'b0;
   endtask

   task automatic do_commit(input bit we, input int s, input int x, input int y, input int id,
                            input int en);
      DrawX    = 10'd0;
      DrawY    = 10'd480;
      blank    = 1'b0;
      cfg_slot = 2'(s);
      cfg_x    = 10'(x);
      cfg_y    = 10'(y);
      cfg_id   = 3'(id);
      cfg_en   = 1'(en);
      cfg_we   = we;
      step();
      cfg_we   = 1'b0;
      chk("frame_commit_high", int'(frame_commit), 1);
      DrawX    = 10'd1;
      step();
      chk("frame_commit_low", int'(frame_commit), 0);
   endtask

   task automatic apply(input string tag, input int x, input int y, input bit b, input int romv,
                        input int e_addr, input int e_idx, input bit e_hit, input int e_slot);
      DrawX   = 10'(x);
      DrawY   = 10'(y);
      blank   = b;
      rom_val = romv;
      step();
      chk({tag, "_rom_address"}, int'(rom_address), e_addr);
      step();
      chk({tag, "_pix_index"}, int'(pix_index), e_idx);
      chk({tag, "_pix_hit"}, int'(pix_hit), int'(e_hit));
      chk({tag, "_pix_slot"}, int'(pix_slot), e_slot);
   endtask

   task automatic run_group(input int g);
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].grp == g) begin
            apply($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].b, vecs[i].romv,
                  vecs[i].addr, vecs[i].idx, vecs[i].hit, vecs[i].slot);
         end
      end
   endtask

   initial begin
      // grp 0: slot0 @ (100,50) id1
      vecs[0]  = '{0, 100,  50, 1, 5,  625, 5, 1, 0};
      vecs[1]  = '{0, 125,  50, 1, 5,    0, 0, 0, 0};
      vecs[2]  = '{0, 124,  74, 1, 7, 1249, 7, 1, 0};
      vecs[3]  = '{0,  99,  50, 1, 7,    0, 0, 0, 0};
      vecs[4]  = '{0, 100,  75, 1, 7,    0, 0, 0, 0};
      vecs[5]  = '{0, 110,  60, 0, 7,    0, 0, 0, 0};
      // grp 1: s0 (190,190,id0) s1 (630,470,id2) s2 (195,195,id3) s3 (1020,0,id7)
      vecs[6]  = '{1, 200, 200, 1, 9,  260, 9, 1, 0};
      vecs[7]  = '{1, 200, 200, 1, 0,  260, 0, 0, 0};
      vecs[8]  = '{1, 214, 214, 1, 3,  624, 3, 1, 0};
      vecs[9]  = '{1, 215, 215, 1, 3, 2395, 3, 1, 2};
      vecs[10] = '{1, 215, 215, 1, 0, 2395, 0, 0, 2};
      vecs[11] = '{1, 639, 479, 1, 4, 1484, 4, 1, 1};
      vecs[12] = '{1, 639, 479, 0, 4,    0, 0, 0, 0};
      vecs[13] = '{1,1023,  10, 1, 4, 4628, 4, 1, 3};
      vecs[14] = '{1,   5,  10, 1, 4,    0, 0, 0, 0};
      vecs[15] = '{1, 640, 479, 1, 6, 1485, 6, 1, 1};
      // grp 2: slot0 disabled, slot2 wins at (200,200)
      vecs[16] = '{2, 200, 200, 1, 9, 2005, 9, 1, 2};

      Reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0;
      cfg_we = 1'b0; cfg_slot = '0; cfg_x = '0; cfg_y = '0; cfg_id = '0; cfg_en = 1'b0;
      step();
      step();
      chk("reset_rom_address", int'(rom_address), 0);
      chk("reset_pix_index", int'(pix_index), 0);
      chk("reset_pix_hit", int'(pix_hit), 0);
      chk("reset_frame_commit", int'(frame_commit), 0);
      Reset = 1'b0;
      step();

      cfg_write(0, 100, 50, 1, 1);
      apply("precommit", 100, 50, 1, 5, 0, 0, 0, 0);
      do_commit(1'b0, 0, 0, 0, 0, 0);
      run_group(0);

      cfg_write(0, 190, 190, 0, 1);
      cfg_write(1, 630, 470, 2, 1);
      cfg_write(2, 195, 195, 3, 1);
      cfg_write(3, 1020, 0, 7, 1);
      do_commit(1'b0, 0, 0, 0, 0, 0);
      run_group(1);

      cfg_write(0, 190, 190, 0, 0);
      do_commit(1'b0, 0, 0, 0, 0, 0);
      run_group(2);

      // Mid-frame shadow write must not disturb the current frame.
      DrawX = 10'd200;
      DrawY = 10'd100;
      blank = 1'b1;
      cfg_write(1, 200, 200, 1, 1);
      apply("midframe", 200, 200, 1, 9, 2005, 9, 1, 2);
      // Write on the commit cycle lands in shadow only.
      do_commit(1'b1, 1, 200, 200, 1, 0);
      apply("commit_same_cycle", 200, 200, 1, 9, 625, 9, 1, 1);
      do_commit(1'b0, 0, 0, 0, 0, 0);
      apply("next_frame", 200, 200, 1, 9, 2005, 9, 1, 2);

      // Asynchronous reset between edges while a hit is showing.
      chk("pre_reset_hit", int'(pix_hit), 1);
      #3;
      Reset = 1'b1;
      #1;
      chk("async_rom_address", int'(rom_address), 0);
      chk("async_pix_index", int'(pix_index), 0);
      chk("async_pix_hit", int'(pix_hit), 0);
      chk("async_pix_slot", int'(pix_slot), 0);
      chk("async_frame_commit", int'(frame_commit), 0);
      step();
      Reset = 1'b0;
      apply("post_reset_nocommit", 200, 200, 1, 9, 0, 0, 0, 0);
      do_commit(1'b0, 0, 0, 0, 0, 0);
      apply("post_reset_commit", 200, 200, 1, 9, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Per-pixel sprite scheduler that shares the single sprite ROM port among `NUM_SPRITES` on-screen object slots (player, enemies, bullets). Each `vga_clk` it does three things: finds the highest-priority enabled slot covering (`DrawX`, `DrawY`), issues that slot's ROM address, and returns the ROM colour index tagged with slot and hit status for the palette/compositing stage. Game logic writes slot configuration (position, sprite id, enable) at any time into shadow registers. These are committed to the active set once per frame so on-screen objects never tear.

## Interface
- `NUM_SPRITES`, 4: number of sprite slots; slot 0 has highest priority.
- `SPR_W`, 25: sprite width in pixels.
- `SPR_H`, 25: sprite height in pixels.
- `ID_W`, 3: sprite id width; image `id` starts at ROM word `id*SPR_W*SPR_H`.
- `ADDR_W`, 13: ROM address width; must hold `(2^ID_W)*SPR_W*SPR_H - 1`.
- `COMMIT_Y`, 480: `DrawY` line on which shadow→active commit occurs.
- `vga_clk` input 1: pixel clock; all state on rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `DrawX`, `DrawY` input 10 each: current pixel coordinate.
- `blank` input 1: 1 = visible region, 0 = blanking.
- `cfg_we` input 1: shadow write strobe.
- `cfg_slot` input `$clog2(NUM_SPRITES)`: slot written.
- `cfg_x`, `cfg_y` input 10 each: sprite top-left corner.
- `cfg_id` input `ID_W`: sprite image id.
- `cfg_en` input 1: slot enable.
- `rom_address` output `ADDR_W`: registered address to shared sprite ROM.
- `rom_q` input 4: ROM colour index; valid one cycle after `rom_address` (ROM read on negedge).
- `pix_index` output 4: colour index for palette; 0 when no hit.
- `pix_hit` output 1: opaque sprite pixel present.
- `pix_slot` output `$clog2(NUM_SPRITES)`: winning slot; 0 when no hit.
- `frame_commit` output 1: one-cycle pulse on the cycle after commit.

## Operation
- **Shadow bank.** A `cfg_we` cycle writes `cfg_x/y/id/en` into shadow[`cfg_slot`]. A `cfg_slot >= NUM_SPRITES` write is ignored.
- **Commit.** When `DrawX==0 && DrawY==COMMIT_Y`, active ← shadow for all slots. The copy uses shadow contents before that edge: a `cfg_we` on the same cycle lands in shadow only and takes effect next frame.
- **Hit test, per slot, on active registers.** Comparisons use 11-bit arithmetic so `x+SPR_W` never wraps.
  - `dx = DrawX - x`, `dy = DrawY - y`.
  - hit = `en && blank && DrawX>=x && DrawX<x+SPR_W && DrawY>=y && DrawY<y+SPR_H`.
  - Sprites extending past 639/479 are clipped naturally.
- **Arbitration.** Fixed priority, lowest hitting slot index wins. There is no fall-through: if the winner's pixel is index 0 (transparent), lower-priority slots are not shown for that pixel, and the background shows.
- **Address.** `id*SPR_W*SPR_H + dy*SPR_W + dx` for the winning slot, truncated to `ADDR_W`. With no hit, address 0 is issued.
- **Pipeline.**
  - S1 registers `rom_address`, `hit1`, `slot1`.
  - S2 registers `pix_index = hit1 ? rom_q : 0`, `pix_hit = hit1 && rom_q!=0`, `pix_slot = hit1 ? slot1 : 0`.
- **Reset.** All shadow and active registers clear (every slot disabled, x=y=id=0). `rom_address`, `pix_index`, `pix_hit`, `pix_slot` and `frame_commit` all reset to 0.

## Timing
- **Latency.** Coordinates sampled at edge N produce `rom_address` valid after edge N+1 and `pix_*` valid after edge N+2, a fixed 2 cycles. Downstream delays `DrawX/DrawY/blank` by 2 to align.
- **Throughput.** One pixel per cycle, no stalls, no handshake.
- **Config writes.** A write is visible in shadow the cycle after `cfg_we`. It affects output only after the next commit, so `pix_*` changes at earliest 2 cycles after the commit edge.
- **`frame_commit`.** High for exactly one cycle, following the commit edge.
- **Reset mid-frame.** Reset asserted mid-frame clears state immediately (asynchronously). Output stays no-hit until a commit occurs after configuration is written.
- **Width rules.** `blank==0` forces no hit regardless of position. Coordinates ≥ 640/480 can still hit if `blank` is high; `blank` is authoritative.

## Test plan
- **Basic hit.** Reset, write slot0 `x=100,y=50,id=1,en=1`, run to commit. At pixel (100,50), `rom_address`=625 one cycle later. With `rom_q`=5, expect `pix_index`=5, `pix_hit`=1, `pix_slot`=0 two cycles after sampling. At (125,50), `pix_hit`=0.
- **Priority.** Slots 0 and 2 both cover (200,200), slot0 id=0 at (190,190). Expect address `10*25+10=260`, `pix_slot`=0. With slot0 disabled, expect `pix_slot`=2.
- **Transparency.** Winning slot returns `rom_q`=0. Expect `pix_hit`=0, `pix_index`=0, even though a lower-priority slot overlaps.
- **Commit isolation.** Write slot1 mid-frame (DrawY=100): output unchanged for the rest of that frame. Write with `cfg_we` on the commit cycle itself: not applied until the following frame's commit. Check the `frame_commit` pulse width is 1.
- **Edge clipping.** Slot at `x=630,y=470`: hits at (639,479) with `dx=9,dy=9`. No hit when `blank`=0. A slot at `x=1020` never hits visible pixels, and no wrap occurs.
- **Async reset.** Assert `Reset` between clock edges while `pix_hit`=1. Expect all outputs 0 immediately and the slot disabled after release.
